// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - PRBS7 constants and Fibonacci LFSR step function
package prbs_pkg;

  localparam int ORDER = 7;
  localparam int TAP_A = 6;
  localparam int TAP_B = 5;
  localparam logic [ORDER-1:0] DEFAULT_SEED = 7'h7F;

  // x^7 + x^6 + 1, shift left, feedback enters at bit 0
  function automatic logic [ORDER-1:0] lfsr_step(input logic [ORDER-1:0] s);
    return {s[ORDER-2:0], s[TAP_A] ^ s[TAP_B]};
  endfunction

endpackage

// File: rtl/prbs_gen.sv
// rtl/prbs_gen.sv - PRBS7 LFSR with registered output bit and zero-state recovery
module prbs_gen
  import prbs_pkg::*;
#(
  parameter logic [ORDER-1:0] SEED = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  output logic             bit_out,
  output logic [ORDER-1:0] state
);

  // A zero seed would lock the LFSR up, so substitute the default.
  localparam logic [ORDER-1:0] SEED_EFF = (SEED == '0) ? DEFAULT_SEED : SEED;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SEED_EFF;
      bit_out <= 1'b0;
    end else if (load) begin
      state   <= SEED_EFF;
      bit_out <= 1'b0;
    end else if (en) begin
      bit_out <= state[TAP_A];
      state   <= (state == '0) ? DEFAULT_SEED : lfsr_step(state);
    end
  end

endmodule

// File: rtl/prbs_verify_unit.sv
// rtl/prbs_verify_unit.sv - lock-step PRBS7 generator vs reference with sticky pass flag
module prbs_verify_unit
  import prbs_pkg::*;
#(
  parameter logic [ORDER-1:0] SEED = DEFAULT_SEED
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic pass
);

  logic             gen_bit;
  logic             exp_bit;
  logic [ORDER-1:0] gen_state;
  logic [ORDER-1:0] ref_state;
  logic             cmp_valid;

  prbs_gen #(.SEED(SEED)) u_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .en      (en),
    .bit_out (gen_bit),
    .state   (gen_state)
  );

  prbs_gen #(.SEED(SEED)) u_ref (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .en      (en),
    .bit_out (exp_bit),
    .state   (ref_state)
  );

  // Compare only on enabled cycles; a zero state in either LFSR is a fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_valid <= 1'b0;
      pass      <= 1'b1;
    end else if (load) begin
      cmp_valid <= 1'b0;
      pass      <= 1'b1;
    end else if (en) begin
      cmp_valid <= 1'b1;
      if ((cmp_valid && (gen_bit != exp_bit)) || (gen_state == '0) || (ref_state == '0))
        pass <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prbs_verify_unit.sv
// tb/tb_prbs_verify_unit.sv - self-checking bench for prbs_verify_unit
module tb_prbs_verify_unit;

  logic clk = 1'b0;
  logic reset;
  logic load;
  logic en;
  logic pass;

  int total = 0;
  int bad = 0;

  bit   seq [0:255];
  int   k;
  logic last_bit;
  logic [6:0] tmp;
  logic [13:0] exp14;
  bit   went_low;

  prbs_verify_unit dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .en    (en),
    .pass  (pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // State after n steps is the 7-bit window of the output stream starting at n.
  function automatic logic [6:0] model_state(input int n);
    int m;
    logic [6:0] s;
    m = n % 127;
    for (int i = 0; i < 7; i++) s[6-i] = seq[m+i];
    return s;
  endfunction

  task automatic run_cycle(input logic ld, input logic e);
    load = ld;
    en   = e;
    @(posedge clk);
    @(negedge clk);
    if (ld) begin
      k = 0;
      last_bit = 1'b0;
    end else if (e) begin
      last_bit = seq[k % 127];
      k++;
    end
    load = 1'b0;
    en   = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_gen_state"}, dut.u_gen.state, model_state(k));
    chk({tag, "_ref_state"}, dut.u_ref.state, model_state(k));
    chk({tag, "_gen_bit"}, dut.u_gen.bit_out, last_bit);
    chk({tag, "_pass"}, pass, 1'b1);
  endtask

  initial begin
    // Output stream: first 7 bits are the seed MSB-first, then o[n] = o[n-7] ^ o[n-6].
    tmp = 7'h7F;
    for (int i = 0; i < 7; i++) seq[i] = tmp[6-i];
    for (int i = 7; i < 256; i++) seq[i] = seq[i-7] ^ seq[i-6];
    k = 0;
    last_bit = 1'b0;

    reset = 1'b1;
    load  = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pass", pass, 1'b1);
    chk("rst_gen_state", dut.u_gen.state, 7'h7F);
    chk("rst_ref_state", dut.u_ref.state, 7'h7F);
    chk("rst_gen_bit", dut.u_gen.bit_out, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_pass", pass, 1'b1);

    // Known 14-bit prefix from seed 7F
    run_cycle(1'b1, 1'b0);
    exp14 = 14'b11111110000001;
    for (int i = 0; i < 14; i++) begin
      run_cycle(1'b0, 1'b1);
      chk("prefix_bit", dut.u_gen.bit_out, exp14[13-i]);
      if (i == 6) chk("state_after7", dut.u_gen.state, 7'h01);
      chk_model("prefix");
    end

    // Run on to 96 enabled cycles with pass held high
    for (int i = 14; i < 96; i++) begin
      run_cycle(1'b0, 1'b1);
      chk_model("run96");
    end

    // Full period wrap
    run_cycle(1'b1, 1'b0);
    for (int i = 0; i < 127; i++) run_cycle(1'b0, 1'b1);
    chk("wrap_state", dut.u_gen.state, 7'h7F);
    chk("wrap_pass", pass, 1'b1);
    chk_model("wrap");

    // Random enable pattern
    for (int i = 0; i < 150; i++) begin
      run_cycle(1'b0, 1'($urandom_range(0, 1)));
      chk_model("rand");
    end

    // en low for 5 cycles mid-run: everything holds
    tmp = dut.u_gen.state;
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b0, 1'b0);
      chk("hold_state", dut.u_gen.state, model_state(k));
      chk("hold_pass", pass, 1'b1);
    end
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1);
    chk_model("after_hold");

    // load and en together: load wins, no step
    run_cycle(1'b1, 1'b1);
    chk("ld_en_gen_state", dut.u_gen.state, 7'h7F);
    chk("ld_en_ref_state", dut.u_ref.state, 7'h7F);
    chk("ld_en_pass", pass, 1'b1);

    // Fault injection: flip generator MSB for one cycle
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1);
    chk_model("pre_fault");
    tmp = dut.u_gen.state ^ 7'h40;
    force dut.u_gen.state = tmp;
    run_cycle(1'b0, 1'b1);
    release dut.u_gen.state;
    went_low = 1'b0;
    for (int i = 0; i < 2; i++) begin
      run_cycle(1'b0, 1'b1);
      if (pass === 1'b0) went_low = 1'b1;
    end
    chk("fault_detect", went_low, 1'b1);
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b0, 1'($urandom_range(0, 1)));
      chk("fault_sticky", pass, 1'b0);
    end
    run_cycle(1'b1, 1'b0);
    chk("fault_load_pass", pass, 1'b1);
    chk_model("fault_load");

    // Async reset between edges mid-run
    for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pass", pass, 1'b1);
    chk("async_rst_gen_state", dut.u_gen.state, 7'h7F);
    chk("async_rst_ref_state", dut.u_ref.state, 7'h7F);
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    last_bit = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_cycle(1'b0, 1'b1);
      chk("restart_bit", dut.u_gen.bit_out, 1'b1);
      chk_model("restart");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
